// File: rtl/gate_activation.sv
// Element-serial sigmoid/tanh over a packed fixed-point vector.
// PLAN piecewise-linear approximation with a 2-stage pipeline: S1 magnitude/segment, S2 evaluate/write.
module gate_activation #(
    parameter int HIDDEN_SZ = 64,
    parameter int QN        = 6,
    parameter int QM        = 11,
    parameter int ACT_TYPE  = 0,
    localparam int BITWIDTH       = QN + QM + 1,
    localparam int LAYER_BITWIDTH = BITWIDTH * HIDDEN_SZ
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LAYER_BITWIDTH-1:0] gateVec,
    input  logic                      dataReady_gate,
    output logic [LAYER_BITWIDTH-1:0] actOutput,
    output logic                      dataReady_act,
    output logic                      busy
);
    localparam int CW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(HIDDEN_SZ - 1);

    localparam logic [BITWIDTH-1:0] MINC   = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic [BITWIDTH-1:0] MAXC   = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic [BITWIDTH-1:0] ONE    = BITWIDTH'(2**QM);
    localparam logic [BITWIDTH-1:0] C_5    = BITWIDTH'(5 * 2**QM);
    localparam logic [BITWIDTH-1:0] C_2375 = BITWIDTH'(19 * 2**(QM-3));
    localparam logic [BITWIDTH-1:0] C_084  = BITWIDTH'(27 * 2**(QM-5));
    localparam logic [BITWIDTH-1:0] C_0625 = BITWIDTH'(5 * 2**(QM-3));
    localparam logic [BITWIDTH-1:0] HALF   = BITWIDTH'(2**(QM-1));

    typedef enum logic [1:0] {IDLE, PROC, DRAIN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      prev_q;
    logic                      start;
    logic [LAYER_BITWIDTH-1:0] vec_q, act_q;

    logic                      s1_vld_q, s1_neg_q;
    logic [BITWIDTH-1:0]       s1_a_q;
    logic [1:0]                s1_seg_q;
    logic [CW-1:0]             s1_idx_q;

    logic [BITWIDTH-1:0]       x_w, xp_w, a_w, y_w, res_w;
    logic [1:0]                seg_w;

    // Gating with reset keeps busy low while reset is held, even with dataReady_gate high.
    assign start = reset && dataReady_gate && !prev_q && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  if (start) state_d = PROC;
            PROC: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = DRAIN;
            end
            DRAIN: if (!s1_vld_q) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) cnt_d = '0;
    end

    // S1 front end: optional tanh pre-scale, magnitude with min-code saturation, segment select.
    always_comb begin
        x_w  = vec_q[cnt_q*BITWIDTH +: BITWIDTH];
        xp_w = x_w;
        if (ACT_TYPE == 1)
            xp_w = (x_w[BITWIDTH-1] != x_w[BITWIDTH-2]) ? (x_w[BITWIDTH-1] ? MINC : MAXC)
                                                        : {x_w[BITWIDTH-2:0], 1'b0};
        if (xp_w == MINC)          a_w = MAXC;
        else if (xp_w[BITWIDTH-1]) a_w = -xp_w;
        else                       a_w = xp_w;
        if (a_w >= C_5)         seg_w = 2'd3;
        else if (a_w >= C_2375) seg_w = 2'd2;
        else if (a_w >= ONE)    seg_w = 2'd1;
        else                    seg_w = 2'd0;
    end

    // S2: y stays within [0, ONE], so 1-y and 2y-1 cannot overflow BITWIDTH.
    always_comb begin
        case (s1_seg_q)
            2'd3:    y_w = ONE;
            2'd2:    y_w = (s1_a_q >> 5) + C_084;
            2'd1:    y_w = (s1_a_q >> 3) + C_0625;
            default: y_w = (s1_a_q >> 2) + HALF;
        endcase
        if (s1_neg_q) y_w = ONE - y_w;
        res_w = y_w;
        if (ACT_TYPE == 1) res_w = (y_w << 1) - ONE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            vec_q    <= '0;
            act_q    <= '0;
            s1_vld_q <= 1'b0;
            s1_neg_q <= 1'b0;
            s1_a_q   <= '0;
            s1_seg_q <= '0;
            s1_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= dataReady_gate;
            s1_vld_q <= (state_q == PROC);
            if (start) vec_q <= gateVec;
            if (state_q == PROC) begin
                s1_neg_q <= xp_w[BITWIDTH-1];
                s1_a_q   <= a_w;
                s1_seg_q <= seg_w;
                s1_idx_q <= cnt_q;
            end
            if (s1_vld_q) act_q[s1_idx_q*BITWIDTH +: BITWIDTH] <= res_w;
        end
    end

    assign actOutput     = act_q;
    assign dataReady_act = (state_q == DONE);
    assign busy          = (state_q != IDLE) || start;

endmodule

// File: tb/tb_gate_activation.sv
// Bench for gate_activation: sigmoid and tanh instances share stimulus; results checked
// against an integer model of the PLAN rules.
module tb_gate_activation;
    localparam int HS   = 64;
    localparam int QN   = 6;
    localparam int QM   = 11;
    localparam int B    = QN + QM + 1;
    localparam int LW   = B * HS;
    localparam int ONE  = 1 << QM;
    localparam int MAXV = (1 << (B-1)) - 1;
    localparam int MINV = -(1 << (B-1));

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          dataReady_gate = 1'b0;
    logic [LW-1:0] gateVec = '0;
    logic [LW-1:0] act_s, act_t, last_s, last_t;
    logic          rdy_s, rdy_t, busy_s, busy_t;

    int ncmp = 0;
    int nerr = 0;
    int vecs [2][HS];

    always #5 clock = ~clock;

    gate_activation #(.HIDDEN_SZ(HS), .QN(QN), .QM(QM), .ACT_TYPE(0)) u_sig (
        .clock(clock), .reset(reset), .gateVec(gateVec), .dataReady_gate(dataReady_gate),
        .actOutput(act_s), .dataReady_act(rdy_s), .busy(busy_s));

    gate_activation #(.HIDDEN_SZ(HS), .QN(QN), .QM(QM), .ACT_TYPE(1)) u_tanh (
        .clock(clock), .reset(reset), .gateVec(gateVec), .dataReady_gate(dataReady_gate),
        .actOutput(act_t), .dataReady_act(rdy_t), .busy(busy_t));

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_act(input int xin, input bit th);
        int x, a, y;
        x = xin;
        if (th) begin
            x = 2 * x;
            if (x > MAXV) x = MAXV;
            if (x < MINV) x = MINV;
        end
        a = (x < 0) ? -x : x;
        if (a > MAXV) a = MAXV;
        if (a >= 5 * ONE)          y = ONE;
        else if (8 * a >= 19 * ONE) y = a / 32 + (27 * ONE) / 32;
        else if (a >= ONE)         y = a / 8 + (5 * ONE) / 8;
        else                       y = a / 4 + ONE / 2;
        if (x < 0) y = ONE - y;
        if (th) y = 2 * y - ONE;
        return y;
    endfunction

    function automatic logic [LW-1:0] pack(input int w);
        logic [LW-1:0] p;
        p = '0;
        for (int i = 0; i < HS; i++) p[i*B +: B] = B'(vecs[w][i]);
        return p;
    endfunction

    task automatic gen(input int w);
        for (int i = 0; i < HS; i++) begin
            if ($urandom_range(0, 3) == 0)
                vecs[w][i] = int'($urandom_range(0, (1 << B) - 1)) - (1 << (B-1));
            else
                vecs[w][i] = int'($urandom_range(0, 24000)) - 12000;
        end
    endtask

    function automatic int elem(input logic [LW-1:0] v, input int i);
        return int'($signed(v[i*B +: B]));
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_act_sig"}, int'(|act_s), 0);
        chk({tag, "_act_tanh"}, int'(|act_t), 0);
        chk({tag, "_rdy_sig"}, int'(rdy_s), 0);
        chk({tag, "_rdy_tanh"}, int'(rdy_t), 0);
        chk({tag, "_busy_sig"}, int'(busy_s), 0);
        chk({tag, "_busy_tanh"}, int'(busy_t), 0);
    endtask

    // mode 0: normal, 1: second edge at start+10, 2: gate held 200 cycles, 3: reset at start+20
    task automatic run(input string tag, input int mode, input int limit);
        int pulses_s = 0, pulses_t = 0, pk_s = -1, pk_t = -1;
        @(negedge clock);
        gateVec = pack(0);
        dataReady_gate = 1'b1;
        #1;
        chk({tag, "_busy_start"}, int'(busy_s), 1);
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            if (rdy_s) begin
                pulses_s++;
                if (pk_s < 0) begin pk_s = k; last_s = act_s; end
            end
            if (rdy_t) begin
                pulses_t++;
                if (pk_t < 0) begin pk_t = k; last_t = act_t; end
            end
            if (pk_s > 0 && pk_s == HS + 3 && k == pk_s) chk({tag, "_busy_at_pulse"}, int'(busy_s), 1);
            if (pk_s > 0 && k == pk_s + 1) chk({tag, "_busy_after"}, int'(busy_s), 0);
            case (mode)
                0: if (k == 1) dataReady_gate = 1'b0;
                1: begin
                    if (k == 5) dataReady_gate = 1'b0;
                    if (k == 10) begin gateVec = pack(1); dataReady_gate = 1'b1; end
                    if (k == 12) dataReady_gate = 1'b0;
                end
                2: if (k == 200) dataReady_gate = 1'b0;
                default: begin
                    if (k == 1) dataReady_gate = 1'b0;
                    if (k == 20) begin reset = 1'b0; #1; check_zero({tag, "_inreset"}); end
                    if (k == 22) reset = 1'b1;
                end
            endcase
        end
        if (mode == 3) begin
            chk({tag, "_pulses_sig"}, pulses_s, 0);
            chk({tag, "_pulses_tanh"}, pulses_t, 0);
        end else begin
            chk({tag, "_pulses_sig"}, pulses_s, 1);
            chk({tag, "_pulses_tanh"}, pulses_t, 1);
            chk({tag, "_lat_sig"}, pk_s, HS + 3);
            chk({tag, "_lat_tanh"}, pk_t, HS + 3);
            for (int i = 0; i < HS; i++) begin
                chk($sformatf("%s_sig[%0d]", tag, i), elem(last_s, i), ref_act(vecs[0][i], 1'b0));
                chk($sformatf("%s_tanh[%0d]", tag, i), elem(last_t, i), ref_act(vecs[0][i], 1'b1));
            end
            chk({tag, "_hold_sig"}, elem(act_s, HS-1), ref_act(vecs[0][HS-1], 1'b0));
        end
    endtask

    initial begin
        int dir [16] = '{0, 2048, -2048, 12288, -131072, 4096, 8192, 20480,
                         10240, 10239, 4864, 4863, -1, 131071, 2560, -2560};
        int exp_s [7] = '{1024, 1536, 512, 2048, 0, 1792, 1984};
        last_s = '0;
        last_t = '0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b1;
        @(negedge clock);

        gen(0);
        gen(1);
        for (int i = 0; i < 16; i++) vecs[0][i] = dir[i];
        run("dir", 0, 90);
        for (int i = 0; i < 7; i++) chk($sformatf("dir_const_sig[%0d]", i), elem(last_s, i), exp_s[i]);
        chk("dir_const_tanh[0]", elem(last_t, 0), 0);
        chk("dir_const_tanh[1]", elem(last_t, 1), 1536);
        chk("dir_const_tanh[2]", elem(last_t, 2), -1536);
        chk("dir_const_tanh[7]", elem(last_t, 7), 2048);

        gen(0);
        gen(1);
        run("reedge", 1, 90);
        gen(0);
        run("hold", 2, 210);
        gen(0);
        run("rst", 3, 90);
        gen(0);
        run("post", 0, 90);
        for (int r = 0; r < 3; r++) begin
            gen(0);
            run($sformatf("rnd%0d", r), 0, 90);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/gate_activation.md
GATE_ACTIVATION -- requirements
Module: gate_activation

Interface
REQ-001 SHALL have parameter HIDDEN_SZ, default 64, number of elements in the gate vector.
REQ-002 SHALL have parameter QN, default 6, integer bits of the signed fixed-point format.
REQ-003 SHALL have parameter QM, default 11, fractional bits; QM >= 5 is required.
REQ-004 SHALL have parameter ACT_TYPE, default 0, selecting the function: 0 = sigmoid, 1 = tanh.
REQ-005 SHALL derive BITWIDTH = QN+QM+1 and LAYER_BITWIDTH = BITWIDTH*HIDDEN_SZ.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clock, input, 1 bit, rising-edge clock.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-009 SHALL have port gateVec, input, LAYER_BITWIDTH bits, packed signed pre-activation vector; element i is at [i*BITWIDTH +: BITWIDTH].
REQ-010 SHALL have port dataReady_gate, input, 1 bit, high while gateVec is valid.
REQ-011 SHALL have port actOutput, output reg, LAYER_BITWIDTH bits, packed signed activated vector using the same element layout.
REQ-012 SHALL have port dataReady_act, output, 1 bit, one-cycle pulse when actOutput is complete.
REQ-013 SHALL have port busy, output, 1 bit, high from the start cycle until the dataReady_act pulse, inclusive.

Function
REQ-014 SHALL start a run on a rising edge of dataReady_gate (current 1, registered previous 0) while in IDLE, capturing gateVec into an internal vector register in that cycle.
REQ-015 SHALL ignore dataReady_gate edges while busy; no recapture and no restart.
REQ-016 SHALL implement states IDLE -> PROC (on start), PROC -> DRAIN (after the last element is issued), DRAIN -> DONE (after the pipeline empties), DONE -> IDLE (unconditionally, 1 cycle).
REQ-017 SHALL issue one element per cycle in PROC, index 0..HIDDEN_SZ-1, using a log2(HIDDEN_SZ)-bit counter that clears to 0 on entry to IDLE.
REQ-018 SHALL process elements in a 2-stage pipeline: S1 registers sign, |x| and segment select; S2 computes y and writes element idx of actOutput.
REQ-019 SHALL saturate |x| of the most-negative code to the maximum positive code.
REQ-020 SHALL, for ACT_TYPE=1, use x' = sat(2x) in place of x (saturation to the BITWIDTH signed range) before S1.
REQ-021 SHALL compute sigmoid PLAN segments on a = |x'|, with constants scaled by 2^QM and right shifts truncating:
 - a >= 5.0: y = 1.0
 - 2.375 <= a < 5.0: y = (a>>5) + 0.84375
 - 1.0 <= a < 2.375: y = (a>>3) + 0.625
 - a < 1.0: y = (a>>2) + 0.5
REQ-022 SHALL output y for x' >= 0 and 1.0 - y for x' < 0.
REQ-023 SHALL, for ACT_TYPE=1, output 2y - 1.0 (computed as (y<<1) - 2^QM) after the sign correction.
REQ-024 SHALL assert dataReady_act exactly in state DONE, which is HIDDEN_SZ+3 cycles after the start cycle.
REQ-025 SHALL hold actOutput stable from DONE until the first S2 write of the next run; elements not yet rewritten keep their previous values.
REQ-026 SHALL keep all result values within [0, 2^QM] for sigmoid and [-2^QM, 2^QM] for tanh; no overflow is possible.

Reset
REQ-027 SHALL, on reset low and asynchronously, set state=IDLE, counter=0, the pipeline valids=0, the edge-detect register=0, actOutput=0, dataReady_act=0 and busy=0.
REQ-028 SHALL abort any in-flight run on reset with no dataReady_act pulse, and SHALL need a fresh rising edge of dataReady_gate after reset release to start.

Verification
REQ-029 SHALL pass: sigmoid, QM=11, elements {0, 2048, -2048, 12288, -131072} -> {1024, 1536, 512, 2048, 0}, with dataReady_act at start+67 for HIDDEN_SZ=64.
REQ-030 SHALL pass: sigmoid, x=4096 (2.0) -> 512+1280 = 1792; x=8192 (4.0) -> 256+1728 = 1984.
REQ-031 SHALL pass: tanh, elements {0, 2048, -2048, 20480} -> {0, 1536, -1536, 2048}.
REQ-032 SHALL pass: a second dataReady_gate edge at start+10 -> ignored, exactly one dataReady_act pulse, results taken from the first capture.
REQ-033 SHALL pass: reset low at start+20 -> all outputs 0 immediately; no pulse; a new edge after release runs normally.
REQ-034 SHALL pass: dataReady_gate held high for 200 cycles -> exactly one run and one pulse.
